// File: rtl/mem_bus_decoder_pkg.sv
// Shared definitions for the CPU memory-bus decoder: FSM encoding,
// the timeout read-back value and the default address map.
package mem_bus_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAM_WAIT,
    ACK,
    CON_STALL
  } state_e;

  localparam logic [31:0] DEAD_BEEF      = 32'hDEAD_BEEF;
  localparam logic [31:0] DEF_RAM_BYTES  = 32'd131072;
  localparam logic [31:0] DEF_CON_ADDR   = 32'h1000_0000;
  localparam logic [31:0] DEF_PASS_ADDR  = 32'h2000_0000;
  localparam logic [31:0] DEF_PASS_MAGIC = 32'd123456789;

endpackage

// File: rtl/mem_bus_decoder_fifo.sv
// Synchronous circular FIFO; pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits match.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop while full only frees the slot for the following cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mem_bus_decoder.sv
// Decodes CPU native-bus requests onto RAM, a console byte FIFO and a
// test-result register, with a RAM response timeout.
module mem_bus_decoder
  import mem_bus_decoder_pkg::*;
#(
  parameter logic [31:0] RAM_BYTES  = DEF_RAM_BYTES,
  parameter logic [31:0] CON_ADDR   = DEF_CON_ADDR,
  parameter logic [31:0] PASS_ADDR  = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_MAGIC = DEF_PASS_MAGIC,
  parameter logic [7:0]  TIMEOUT    = 8'd255,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        ram_valid,
  input  logic        ram_ready,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic [31:0] ram_rdata,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_data,
  output logic        tests_passed,
  output logic        bus_error
);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic        passed_q, passed_d;
  logic        err_q, err_d;
  logic        fifo_push;
  logic        fifo_full;
  logic        fifo_empty;
  logic        is_write;

  assign is_write = (mem_wstrb != 4'b0000);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    passed_d  = passed_q;
    err_d     = err_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          wait_d  = '0;
          rdata_d = '0;
          if (mem_addr < RAM_BYTES) begin
            state_d = RAM_WAIT;
          end else if (mem_addr == CON_ADDR && is_write) begin
            state_d = CON_STALL;
          end else begin
            state_d = ACK;
            // Console and pass-register reads are harmless; anything else unmapped is an error.
            if (mem_addr == PASS_ADDR) begin
              if (is_write) passed_d = (mem_wdata == PASS_MAGIC);
            end else if (mem_addr != CON_ADDR) begin
              err_d = 1'b1;
            end
          end
        end
      end
      RAM_WAIT: begin
        if (ram_ready) begin
          rdata_d = ram_rdata;
          state_d = ACK;
        end else if (wait_q == TIMEOUT - 8'd1) begin
          rdata_d = DEAD_BEEF;
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      CON_STALL: begin
        if (!fifo_full) begin
          fifo_push = 1'b1;
          state_d   = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      rdata_q  <= '0;
      passed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      passed_q <= passed_d;
      err_q    <= err_d;
    end
  end

  // The CPU holds its request fields stable, so RAM sees them directly.
  assign ram_valid    = (state_q == RAM_WAIT);
  assign ram_addr     = mem_addr;
  assign ram_wdata    = mem_wdata;
  assign ram_wstrb    = mem_wstrb;
  assign mem_ready    = (state_q == ACK);
  assign mem_rdata    = rdata_q;
  assign tests_passed = passed_q;
  assign bus_error    = err_q;
  assign con_valid    = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (fifo_push),
    .data_i  (mem_wdata[7:0]),
    .pop_i   (con_ready),
    .data_o  (con_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
